// File: rtl/seq_div_16_8_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side (requester) drives start and operands; the slave side
// (divider) returns status and results.
interface seq_div_16_8_if #(
    parameter int N = 8
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_div_16_8.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per clock. Quotient bits are shifted into the LSB of the
// dividend shift register as dividend bits leave its MSB, so after 2N
// steps that register holds the full quotient. Published results only
// change when a division completes, so they stay stable during CALC.
module seq_div_16_8 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           resetn,
    seq_div_16_8_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      pr_q, pr_d;
    logic [W-1:0]    sr_q, sr_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    // The partial remainder is always below the divisor, so its top bit
    // never feeds the next step; only the N+1 bit trial value needs it.
    logic [N:0]      trial;
    logic [N:0]      diff;
    logic            qbit;
    logic            unused_pr_msb;

    assign trial         = {pr_q[N-1:0], sr_q[W-1]};
    assign diff          = trial - {1'b0, dvs_q};
    assign qbit          = (trial >= {1'b0, dvs_q});
    assign unused_pr_msb = pr_q[N];

    // State and datapath registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pr_q    <= '0;
            sr_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            sr_q    <= sr_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state, iteration step and registered-output values.
    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        sr_d    = sr_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        pr_d    = '0;
                        sr_d    = bus.dividend;
                        dvs_d   = bus.divisor;
                        cnt_d   = CW'(W - 1);
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else begin
                        // Divide by zero short-circuits straight to DONE.
                        quot_d  = '1;
                        rem_d   = bus.dividend[N-1:0];
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CALC: begin
                busy_d = 1'b1;
                pr_d   = qbit ? diff : trial;
                sr_d   = {sr_q[W-2:0], qbit};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = sr_d;
                    rem_d   = pr_d[N-1:0];
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
endmodule
